// File: rtl/hdc_pkg.sv
// Shared HDC definitions: FSM states, default sizes and the hypervector type.
// Used by the LFSR source, the item memory and the encoder.
package hdc_pkg;

    localparam int DEFAULT_DIM     = 1024;
    localparam int DEFAULT_NUM_HVS = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_t;

    typedef logic [DEFAULT_DIM-1:0] hv_t;

endpackage

// File: rtl/hv_shift_reg.sv
// One item hypervector: right-shift register, new bit enters at the MSB.
// Synchronous clear has priority over shifting.
module hv_shift_reg #(
    parameter int DIM = 1024
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           shift_en,
    input  logic           bit_in,
    output logic [DIM-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {bit_in, q[DIM-1:1]};
        end
    end

endmodule

// File: rtl/hv_item_memory.sv
// Item memory: serially fills NUM_HVS random hypervectors from LFSR beats
// and serves them through a one-cycle registered read port.
module hv_item_memory
    import hdc_pkg::*;
#(
    parameter int NUM_HVS = DEFAULT_NUM_HVS,
    parameter int DIM     = DEFAULT_DIM,
    parameter int ADDR_W  = $clog2(NUM_HVS),
    parameter int CNT_W   = $clog2(DIM + 1)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic [NUM_HVS-1:0] rnd_in,
    input  logic               rnd_valid,
    output logic               busy,
    output logic               done,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_valid,
    output logic [DIM-1:0]     rd_data
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             shift_en;
    logic             clr_cnt;
    logic             last_beat;
    logic             rd_hit;
    logic [DIM-1:0]   rd_mux;
    logic [DIM-1:0]   hv [NUM_HVS];

    assign shift_en  = (state == FILL) && rnd_valid;
    assign last_beat = shift_en && (cnt == CNT_W'(DIM - 1));
    assign busy      = (state == FILL);
    assign done      = (state == READY);
    assign rd_hit    = rd_en && (state == READY);

    always_comb begin
        state_nxt = state;
        clr_cnt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FILL;
                    clr_cnt   = 1'b1;
                end
            end
            FILL: begin
                if (last_beat) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (start) begin
                    state_nxt = FILL;
                    clr_cnt   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (clr_cnt) begin
                cnt <= '0;
            end else if (shift_en) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Storage reset rides on the shift registers' synchronous clear.
    for (genvar i = 0; i < NUM_HVS; i++) begin : g_hv
        hv_shift_reg #(
            .DIM(DIM)
        ) u_sr (
            .clk     (clk),
            .clr     (!nrst),
            .shift_en(shift_en),
            .bit_in  (rnd_in[i]),
            .q       (hv[i])
        );
    end

    // Addresses past the last hypervector match nothing and read as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_HVS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_mux = hv[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_hit;
            if (rd_hit) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_hv_item_memory.sv
// Directed bench for hv_item_memory: small DIM=8/NUM_HVS=3 instance plus a
// default-size instance for the full-length fill.
module tb_hv_item_memory;

    logic         clk = 1'b0;
    logic         nrst;

    logic         start;
    logic [2:0]   rnd_in;
    logic         rnd_valid;
    logic         busy;
    logic         done;
    logic         rd_en;
    logic [1:0]   rd_addr;
    logic         rd_valid;
    logic [7:0]   rd_data;

    logic         start_b;
    logic [16:0]  rnd_b;
    logic         valid_b;
    logic         busy_b;
    logic         done_b;
    logic         rd_en_b;
    logic [4:0]   addr_b;
    logic         rdv_b;
    logic [1023:0] rdd_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hv_item_memory #(
        .NUM_HVS(3),
        .DIM    (8)
    ) u_dut (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start),
        .rnd_in   (rnd_in),
        .rnd_valid(rnd_valid),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    hv_item_memory u_big (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start_b),
        .rnd_in   (rnd_b),
        .rnd_valid(valid_b),
        .busy     (busy_b),
        .done     (done_b),
        .rd_en    (rd_en_b),
        .rd_addr  (addr_b),
        .rd_valid (rdv_b),
        .rd_data  (rdd_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1023:0] obs,
                       input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp,
                      input string tag);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
        chk({tag, "_v"}, 1024'(rd_valid), 1024'(1));
        chk({tag, "_d"}, 1024'(rd_data), 1024'(exp));
    endtask

    initial begin
        nrst = 1'b0; start = 1'b0; rnd_in = '0; rnd_valid = 1'b0;
        rd_en = 1'b0; rd_addr = '0;
        start_b = 1'b0; rnd_b = '0; valid_b = 1'b0;
        rd_en_b = 1'b0; addr_b = '0;

        // Reset
        tick(); tick();
        chk("rst_busy", 1024'(busy), 1024'(0));
        chk("rst_done", 1024'(done), 1024'(0));
        chk("rst_rdv",  1024'(rd_valid), 1024'(0));
        chk("rst_rdd",  1024'(rd_data), 1024'(0));
        nrst = 1'b1;
        tick();

        // Constant fill, 8 consecutive beats of 101
        start = 1'b1;
        tick();
        start = 1'b0;
        rnd_valid = 1'b1;
        rnd_in = 3'b101;
        for (int i = 0; i < 8; i++) begin
            chk("fill_busy", 1024'(busy), 1024'(1));
            chk("fill_done", 1024'(done), 1024'(0));
            tick();
        end
        chk("c_done", 1024'(done), 1024'(1));
        chk("c_busy", 1024'(busy), 1024'(0));
        // READY must ignore further beats
        rnd_in = 3'b010;
        rd(2'd0, 8'hFF, "c_rd0");
        rd(2'd1, 8'h00, "c_rd1");
        rd(2'd2, 8'hFF, "c_rd2");
        rnd_valid = 1'b0;
        tick();
        chk("hold_v", 1024'(rd_valid), 1024'(0));
        chk("hold_d", 1024'(rd_data), 1024'(8'hFF));

        // Bit order; read at start is served from old storage
        start = 1'b1; rd_en = 1'b1; rd_addr = 2'd1;
        tick();
        start = 1'b0;
        chk("st_rdv",  1024'(rd_valid), 1024'(1));
        chk("st_rdd",  1024'(rd_data), 1024'(8'h00));
        chk("st_done", 1024'(done), 1024'(0));
        chk("st_busy", 1024'(busy), 1024'(1));
        rd_addr = 2'd0;
        rnd_valid = 1'b1; rnd_in = 3'b001;
        tick();
        rd_en = 1'b0;
        chk("fill_rdv", 1024'(rd_valid), 1024'(0));
        chk("fill_rdd", 1024'(rd_data), 1024'(8'h00));
        rnd_in = 3'b010;
        for (int i = 0; i < 7; i++) tick();
        rnd_valid = 1'b0;
        chk("b_done", 1024'(done), 1024'(1));

        // Back-to-back reads
        rd_en = 1'b1; rd_addr = 2'd2;
        tick();
        chk("bb0_v", 1024'(rd_valid), 1024'(1));
        chk("bb0_d", 1024'(rd_data), 1024'(8'h00));
        rd_addr = 2'd0;
        tick();
        chk("bb1_v", 1024'(rd_valid), 1024'(1));
        chk("bb1_d", 1024'(rd_data), 1024'(8'h01));
        rd_addr = 2'd3;
        tick();
        chk("bb2_v", 1024'(rd_valid), 1024'(1));
        chk("bb2_d", 1024'(rd_data), 1024'(8'h00));
        rd_addr = 2'd1;
        tick();
        rd_en = 1'b0;
        chk("bb3_v", 1024'(rd_valid), 1024'(1));
        chk("bb3_d", 1024'(rd_data), 1024'(8'hFE));

        // Valid gaps with a mid-fill start and junk on idle beats
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            rnd_valid = (k % 2 == 0);
            rnd_in = (k % 2 == 0) ? 3'b101 : 3'b010;
            start = (k == 5);
            chk("gap_done", 1024'(done), 1024'(0));
            tick();
        end
        start = 1'b0; rnd_valid = 1'b0;
        chk("gap_done16", 1024'(done), 1024'(1));
        rd(2'd0, 8'hFF, "g_rd0");
        rd(2'd1, 8'h00, "g_rd1");
        rd(2'd2, 8'hFF, "g_rd2");

        // Reset mid-fill
        start = 1'b1;
        tick();
        start = 1'b0;
        rnd_valid = 1'b1; rnd_in = 3'b111;
        for (int i = 0; i < 4; i++) tick();
        nrst = 1'b0;
        tick(); tick();
        nrst = 1'b1;
        chk("mr_busy", 1024'(busy), 1024'(0));
        chk("mr_done", 1024'(done), 1024'(0));
        chk("mr_rdd",  1024'(rd_data), 1024'(0));
        rd_en = 1'b1; rd_addr = 2'd0;
        tick();
        rd_en = 1'b0;
        chk("idle_rdv", 1024'(rd_valid), 1024'(0));
        chk("idle_busy", 1024'(busy), 1024'(0));
        start = 1'b1; rnd_in = 3'b110;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mr_done7", 1024'(done), 1024'(0));
        tick();
        rnd_valid = 1'b0;
        chk("mr_done8", 1024'(done), 1024'(1));
        rd(2'd0, 8'h00, "m_rd0");
        rd(2'd1, 8'hFF, "m_rd1");

        // Default-size fill takes exactly 1024 beats
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        valid_b = 1'b1; rnd_b = 17'h10001;
        for (int i = 0; i < 1023; i++) tick();
        chk("big_busy", 1024'(busy_b), 1024'(1));
        chk("big_d1023", 1024'(done_b), 1024'(0));
        tick();
        valid_b = 1'b0;
        chk("big_d1024", 1024'(done_b), 1024'(1));
        rd_en_b = 1'b1; addr_b = 5'd16;
        tick();
        chk("big_rdv", 1024'(rdv_b), 1024'(1));
        chk("big_rd16", rdd_b, {1024{1'b1}});
        addr_b = 5'd1;
        tick();
        chk("big_rd1", rdd_b, 1024'(0));
        addr_b = 5'd17;
        rd_en_b = 1'b1;
        tick();
        rd_en_b = 1'b0;
        chk("big_rd17", rdd_b, 1024'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hv_item_memory.md
Name: hv_item_memory

Overview:
- Downstream stage of the LFSR random-bit source.
- Collects one random bit per hypervector per valid cycle and serially builds NUM_HVS binary item hypervectors of DIM bits each.
- Holds the completed set and serves them to the encoder through a registered read port.
- Regeneration is triggered by `start`; a reset returns the block to an empty state.

Parameters:
- NUM_HVS, 17, number of item hypervectors; equals the width of the LFSR output slice.
- DIM, 1024, hypervector dimension in bits.
- ADDR_W, $clog2(NUM_HVS), read address width (derived; not overridden).
- CNT_W, $clog2(DIM+1), fill beat counter width (derived).

Ports:
- clk  in  1  clock; all logic on posedge.
- nrst  in  1  reset; synchronous, active-low.
- start  in  1  begin (re)generation of all hypervectors.
- rnd_in  in  NUM_HVS  random bits; bit i feeds hypervector i.
- rnd_valid  in  1  rnd_in carries a new beat this cycle.
- busy  out  1  fill in progress.
- done  out  1  all hypervectors complete and readable.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  hypervector index to read.
- rd_valid  out  1  rd_data valid this cycle.
- rd_data  out  DIM  requested hypervector.

Behaviour:
- Reset (nrst=0 at posedge), valid in any state including mid-fill:
  - state goes to IDLE and the beat counter goes to 0.
  - all hypervector storage is cleared to 0.
  - busy=0, done=0, rd_valid=0, rd_data=0.
- FSM states: IDLE, FILL, READY.
- IDLE:
  - start=1 goes to FILL and clears the counter.
  - rnd_valid is ignored.
- FILL (busy=1):
  - On each cycle with rnd_valid=1, for every i: hv[i] <= {rnd_in[i], hv[i][DIM-1:1]}, and the counter increments.
  - Bit order: the first beat ends at bit 0 and the last beat at bit DIM-1.
  - start during FILL is ignored; the fill is not restarted.
  - rnd_valid=0 leaves storage and counter unchanged; gaps are unlimited.
  - When the DIM-th valid beat is accepted, the next state is READY.
  - busy deasserts and done asserts in the cycle after that beat.
- READY (done=1):
  - Storage is stable; rnd_valid is ignored.
  - start=1 goes to FILL, clears the counter, and drops done the next cycle.
  - Stored data is overwritten progressively as beats arrive; it is not pre-cleared.
- Read port:
  - Latency is 1 cycle: rd_en=1 at cycle N gives rd_valid=1 and rd_data=hv[rd_addr] at cycle N+1.
  - Back-to-back reads are supported at one per cycle.
  - rd_en is honoured only in READY. In IDLE or FILL it produces rd_valid=0 and rd_data holds its previous value.
  - rd_addr >= NUM_HVS in READY produces rd_valid=1 and rd_data=0.
  - rd_en in the same cycle that start is accepted in READY is still served from pre-restart storage.
  - rd_data holds its value when rd_valid=0.
- No backpressure on rnd_in: the upstream LFSR free-runs, and the block simply samples beats qualified by rnd_valid.

Decomposition:
- Shared package `hdc_pkg`:
  - FSM state enum (IDLE, FILL, READY).
  - default DIM and NUM_HVS constants, shared with the LFSR and encoder.
  - hypervector typedef logic [DIM-1:0].
- One natural sub-module, `hv_shift_reg`: a single DIM-bit right-shift register with shift-enable and synchronous clear.
  - Instantiated NUM_HVS times in a generate loop.
  - The top level holds the FSM, beat counter and read mux/register.

Test Plan (DIM=8, NUM_HVS=3 unless noted):
1. Reset: nrst=0 for 2 cycles at any state -> busy=0, done=0, rd_valid=0, rd_data=0. A read in READY after a fill-then-reset returns rd_valid=0.
2. Constant fill: start, then 8 consecutive beats of rnd_in=3'b101 -> busy high for 8 cycles, done=1 the cycle after the 8th beat. Reads of addr 0/1/2 return 8'hFF/8'h00/8'hFF.
3. Bit order: beat 1 rnd_in=3'b001, beats 2-8 rnd_in=3'b010 -> hv0=8'h01, hv1=8'hFE, hv2=8'h00.
4. Valid gaps plus ignored start: rnd_valid alternating 1/0, start pulsed mid-fill -> done asserts only after the 8th valid beat (cycle 16), same data as scenario 2.
5. Reads: in READY, rd_en on 3 consecutive cycles with addr 2, 0, 3 -> rd_valid=1 on each following cycle, data hv2, hv0, 8'h00. rd_en during FILL -> rd_valid=0.
6. Reset mid-fill: after 4 beats assert nrst=0 -> IDLE, storage 0. A subsequent start requires a full 8 beats before done. Default-parameter smoke test: DIM=1024, NUM_HVS=17 completes in exactly 1024 valid beats.
